// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states,
// requester indices and the word-alignment check.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the port that did not win last time.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       win
);

  always_comb begin
    win = P_CPU;
    if (req == 2'b11) begin
      win = (last == P_CPU) ? P_DBG : P_CPU;
    end else if (req[1]) begin
      win = P_DBG;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer for the single-port data memory shared by the MEM stage
// (port 0) and the debug/loader port (port 1); one access per LAT+1 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          we_q;
  logic          mis_q;
  logic          last;

  logic [1:0]    arb_gnt;
  logic          arb_win;
  logic          grant_ok;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_mis;
  logic [DW-1:0] rd_val;

  rr_arb2 u_rr_arb2 (
    .req  ({p1_req, p0_req}),
    .last (last),
    .gnt  (arb_gnt),
    .win  (arb_win)
  );

  // Grants exist only in IDLE and are held off while reset is asserted.
  assign grant_ok = (state == IDLE) && rst_n;
  assign p0_gnt   = grant_ok && arb_gnt[0];
  assign p1_gnt   = grant_ok && arb_gnt[1];
  assign busy     = (state == ACCESS);

  assign sel_we    = arb_win ? p1_we    : p0_we;
  assign sel_addr  = arb_win ? p1_addr  : p0_addr;
  assign sel_wdata = arb_win ? p1_wdata : p0_wdata;
  assign sel_mis   = misaligned(sel_addr[1:0]);

  // Writes and dropped misaligned accesses return zero data.
  assign rd_val = (we_q || mis_q) ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= P_CPU;
      we_q      <= 1'b0;
      mis_q     <= 1'b0;
      last      <= P_DBG;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_done   <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_done   <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_done  <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_done  <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
      case (state)
        IDLE: begin
          if (arb_gnt != 2'b00) begin
            owner     <= arb_win;
            we_q      <= sel_we;
            mis_q     <= sel_mis;
            last      <= arb_win;
            cnt       <= CNT_LOAD;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_read  <= !sel_we && !sel_mis;
            mem_write <= sel_we && !sel_mis;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // The write strobe lasts one cycle so memory commits exactly once.
          mem_write <= 1'b0;
          if (cnt == '0) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (owner == P_DBG) begin
              p1_done  <= 1'b1;
              p1_err   <= mis_q;
              p1_rdata <= rd_val;
            end else begin
              p0_done  <= 1'b1;
              p0_err   <= mis_q;
              p0_rdata <= rd_val;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
